// File: rtl/operand_regfile.sv
// Operand register file: one write port, two registered read ports, optional
// write-to-read forwarding and an optional hard-wired zero entry.
module operand_regfile #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 8,
   parameter int ADDR_W    = $clog2(DEPTH),
   parameter int BYPASS    = 1,
   parameter int ZERO_REG0 = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              src1_en,
   input  logic [ADDR_W-1:0] src1_addr,
   output logic [DATA_W-1:0] src1_value,
   output logic              src1_valid,
   input  logic              src2_en,
   input  logic [ADDR_W-1:0] src2_addr,
   output logic [DATA_W-1:0] src2_value,
   output logic              src2_valid,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   // One extra bit so that DEPTH itself fits when DEPTH is a power of two.
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic              wr_legal;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_X);
   endfunction

   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
      return (ZERO_REG0 != 0) && (a == '0);
   endfunction

   // Priority: zero entry, out-of-range, forwarded write, stored contents.
   function automatic logic [DATA_W-1:0] resolve(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] r;
      r = '0;
      if (is_zero_reg(a)) begin
         r = '0;
      end else if (!in_range(a)) begin
         r = '0;
      end else if ((BYPASS != 0) && wr_en && (wr_addr == a)) begin
         r = wr_data;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (a == ADDR_W'(i)) r = mem[i];
         end
      end
      return r;
   endfunction

   always_comb begin
      wr_legal = wr_en && in_range(wr_addr) && !is_zero_reg(wr_addr);
   end

   always_comb begin
      rd1 = resolve(src1_addr);
   end

   always_comb begin
      rd2 = resolve(src2_addr);
   end

   // Flop-based storage so that reset clears every entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_legal) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == ADDR_W'(i)) mem[i] <= wr_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src1_value <= '0;
         src1_valid <= 1'b0;
      end else begin
         src1_valid <= src1_en;
         if (src1_en) src1_value <= rd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src2_value <= '0;
         src2_valid <= 1'b0;
      end else begin
         src2_valid <= src2_en;
         if (src2_en) src2_value <= rd2;
      end
   end

endmodule

// File: tb/tb_operand_regfile.sv
// Bench for operand_regfile: three configurations share one stimulus stream and
// are checked against an array-based reference model through expected queues.
module tb_operand_regfile;

   logic        clk;
   logic        rst_n;
   logic        src1_en, src2_en, wr_en;
   logic [2:0]  src1_addr, src2_addr, wr_addr;
   logic [15:0] wr_data;

   logic [7:0]  u0_v1, u0_v2, u1_v1, u1_v2;
   logic [15:0] u2_v1, u2_v2;
   logic        u0_d1, u0_d2, u1_d1, u1_d2, u2_d1, u2_d2;

   int n_cmp = 0;
   int n_err = 0;

   // Configurations: 0 = default, 1 = no bypass + zero reg, 2 = depth 6, 16 bit, zero reg
   int          p_depth [3] = '{8, 8, 6};
   bit          p_byp   [3] = '{1'b1, 1'b0, 1'b1};
   bit          p_zero  [3] = '{1'b0, 1'b1, 1'b1};
   logic [15:0] p_mask  [3] = '{16'h00FF, 16'h00FF, 16'hFFFF};

   logic [15:0] m_mem  [3][8];
   logic [15:0] m_prev [3][2];

   // Entry: {src1_value, src1_valid, src2_value, src2_valid}
   logic [33:0] exp_q0[$];
   logic [33:0] exp_q1[$];
   logic [33:0] exp_q2[$];

   operand_regfile #(.DATA_W(8), .DEPTH(8), .BYPASS(1), .ZERO_REG0(0)) u0 (
      .clk(clk), .rst_n(rst_n),
      .src1_en(src1_en), .src1_addr(src1_addr), .src1_value(u0_v1), .src1_valid(u0_d1),
      .src2_en(src2_en), .src2_addr(src2_addr), .src2_value(u0_v2), .src2_valid(u0_d2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[7:0]));

   operand_regfile #(.DATA_W(8), .DEPTH(8), .BYPASS(0), .ZERO_REG0(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .src1_en(src1_en), .src1_addr(src1_addr), .src1_value(u1_v1), .src1_valid(u1_d1),
      .src2_en(src2_en), .src2_addr(src2_addr), .src2_value(u1_v2), .src2_valid(u1_d2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[7:0]));

   operand_regfile #(.DATA_W(16), .DEPTH(6), .BYPASS(1), .ZERO_REG0(1)) u2 (
      .clk(clk), .rst_n(rst_n),
      .src1_en(src1_en), .src1_addr(src1_addr), .src1_value(u2_v1), .src1_valid(u2_d1),
      .src2_en(src2_en), .src2_addr(src2_addr), .src2_value(u2_v2), .src2_valid(u2_d2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [33:0] act_of(int k);
      case (k)
         0:       return {8'h00, u0_v1, u0_d1, 8'h00, u0_v2, u0_d2};
         1:       return {8'h00, u1_v1, u1_d1, 8'h00, u1_v2, u1_d2};
         default: return {u2_v1, u2_d1, u2_v2, u2_d2};
      endcase
   endfunction

   task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cfg%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
      end
   endtask

   task automatic chk_entry(input string tag, input int k, input logic [33:0] act, input logic [33:0] exp);
      chk({tag, " src1_value"}, k, act[33:18], exp[33:18]);
      chk({tag, " src1_valid"}, k, {15'd0, act[17]}, {15'd0, exp[17]});
      chk({tag, " src2_value"}, k, act[16:1], exp[16:1]);
      chk({tag, " src2_valid"}, k, {15'd0, act[0]}, {15'd0, exp[0]});
   endtask

   // Reference read: behaviour of a register file with optional zero entry and forwarding
   function automatic logic [15:0] m_rdata(int k, logic [2:0] a);
      if (p_zero[k] && a == 3'd0) return 16'h0000;
      if (int'(a) >= p_depth[k]) return 16'h0000;
      if (p_byp[k] && wr_en && wr_addr == a) return wr_data & p_mask[k];
      return m_mem[k][a];
   endfunction

   function automatic void m_clear();
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 8; i++) m_mem[k][i] = 16'h0000;
         m_prev[k][0] = 16'h0000;
         m_prev[k][1] = 16'h0000;
      end
   endfunction

   // Monitor: one expected entry per clock edge per configuration
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            if (exp_q0.size() > 0) chk_entry("rd", 0, act_of(0), exp_q0.pop_front());
            if (exp_q1.size() > 0) chk_entry("rd", 1, act_of(1), exp_q1.pop_front());
            if (exp_q2.size() > 0) chk_entry("rd", 2, act_of(2), exp_q2.pop_front());
         end
      end
   end

   // Driver: called at posedge+2, applies inputs for the next edge and returns at posedge+2
   task automatic cycle(input bit e1, input logic [2:0] a1, input bit e2, input logic [2:0] a2,
                        input bit we, input logic [2:0] wa, input logic [15:0] wd);
      logic [15:0] v1, v2;
      src1_en = e1; src1_addr = a1;
      src2_en = e2; src2_addr = a2;
      wr_en = we; wr_addr = wa; wr_data = wd;
      for (int k = 0; k < 3; k++) begin
         v1 = e1 ? m_rdata(k, a1) : m_prev[k][0];
         v2 = e2 ? m_rdata(k, a2) : m_prev[k][1];
         m_prev[k][0] = v1;
         m_prev[k][1] = v2;
         case (k)
            0:       exp_q0.push_back({v1, e1, v2, e2});
            1:       exp_q1.push_back({v1, e1, v2, e2});
            default: exp_q2.push_back({v1, e1, v2, e2});
         endcase
      end
      for (int k = 0; k < 3; k++) begin
         if (we && int'(wa) < p_depth[k] && !(p_zero[k] && wa == 3'd0))
            m_mem[k][wa] = wd & p_mask[k];
      end
      @(posedge clk);
      #2;
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      cycle(1'b0, 3'd0, 1'b0, 3'd0, 1'b1, a, d);
   endtask

   task automatic idle();
      cycle(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000);
   endtask

   // Asynchronous reset pulse between edges; outputs must clear at once
   task automatic async_reset();
      src1_en = 1'b0; src2_en = 1'b0; wr_en = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) chk_entry("async_reset", k, act_of(k), 34'd0);
      m_clear();
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [2:0]  a1, a2, wa;
      logic [15:0] wd;
      rst_n = 1'b0;
      src1_en = 1'b0; src2_en = 1'b0; wr_en = 1'b0;
      src1_addr = 3'd0; src2_addr = 3'd0; wr_addr = 3'd0; wr_data = 16'h0000;
      m_clear();
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) chk_entry("reset_state", k, act_of(k), 34'd0);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      // Reset clears contents and outputs mid-operation
      for (int i = 0; i < 8; i++) wr(3'(i), 16'h00A5);
      cycle(1'b1, 3'd1, 1'b1, 3'd4, 1'b0, 3'd0, 16'h0000);
      async_reset();
      for (int i = 0; i < 8; i += 2) cycle(1'b1, 3'(i), 1'b1, 3'(i + 1), 1'b0, 3'd0, 16'h0000);

      // Basic write then read, then hold
      wr(3'd3, 16'h004E);
      cycle(1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000);
      chk("basic_read", 0, {8'h00, u0_v1}, 16'h004E);
      idle();
      chk("basic_hold", 0, {8'h00, u0_v1}, 16'h004E);

      // Same-cycle write and read of one address
      wr(3'd5, 16'h0052);
      cycle(1'b0, 3'd0, 1'b1, 3'd5, 1'b1, 3'd5, 16'h0099);
      chk("bypass_on", 0, {8'h00, u0_v2}, 16'h0099);
      chk("bypass_off", 1, {8'h00, u1_v2}, 16'h0052);
      cycle(1'b0, 3'd0, 1'b1, 3'd5, 1'b0, 3'd0, 16'h0000);
      chk("bypass_off_next", 1, {8'h00, u1_v2}, 16'h0099);

      // Both ports together
      wr(3'd2, 16'h00F0);
      wr(3'd7, 16'h000B);
      cycle(1'b1, 3'd2, 1'b1, 3'd7, 1'b0, 3'd0, 16'h0000);
      cycle(1'b1, 3'd7, 1'b1, 3'd7, 1'b0, 3'd0, 16'h0000);

      // Zero register, including forwarded write to entry 0
      wr(3'd0, 16'h00EF);
      cycle(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 16'h0000);
      chk("zero_reg", 1, {8'h00, u1_v1}, 16'h0000);
      cycle(1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd0, 16'h00EF);
      chk("zero_reg_bypass", 2, u2_v1, 16'h0000);

      // Odd depth: address 6 is outside the array
      wr(3'd6, 16'h1234);
      cycle(1'b1, 3'd6, 1'b1, 3'd6, 1'b1, 3'd6, 16'h5678);
      chk("odd_depth_value", 2, u2_v1, 16'h0000);
      chk("odd_depth_valid", 2, {15'd0, u2_d1}, 16'h0001);
      for (int i = 0; i < 6; i += 2) cycle(1'b1, 3'(i), 1'b1, 3'(i + 1), 1'b0, 3'd0, 16'h0000);

      // Randomised traffic with occasional reset pulses
      for (int n = 0; n < 600; n++) begin
         a1 = 3'($urandom_range(0, 7));
         a2 = ($urandom_range(0, 3) == 0) ? a1 : 3'($urandom_range(0, 7));
         wa = ($urandom_range(0, 3) == 0) ? a1 : 3'($urandom_range(0, 7));
         wd = 16'($urandom());
         if ($urandom_range(0, 99) == 0) async_reset();
         cycle(1'($urandom_range(0, 1)), a1, 1'($urandom_range(0, 1)), a2,
               1'($urandom_range(0, 1)), wa, wd);
      end
      idle();

      n_cmp++;
      if (exp_q0.size() + exp_q1.size() + exp_q2.size() != 0) begin
         n_err++;
         $display("FAIL queue_drain: %0d entries left, expected 0",
                  exp_q0.size() + exp_q1.size() + exp_q2.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
